// File: rtl/mem_io_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_io_unit                                            |
// | Description : SLC-3 MAR/MDR owner and memory transaction sequencer  |
// |               (request/ready handshake with a wait-state timeout).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_io_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] Bus_In,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic        Mem_Ready,
  input  logic [15:0] Mem_RData,
  output logic [15:0] MAR_Out,
  output logic [15:0] MDR_Out,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_WData,
  output logic        Mem_Req,
  output logic        Mem_WE,
  output logic        Busy,
  output logic        Done,
  output logic        Err_Flag
);

  typedef enum logic [2:0] {
    c_idle    = 3'd0,
    c_rd_wait = 3'd1,
    c_wr_wait = 3'd2,
    c_done    = 3'd3,
    c_err     = 3'd4
  } state_t;

  // Counter value seen in the last permitted wait cycle; a miss there times out.
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_mar;
  logic [15:0] r_mdr;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic        w_idle;
  logic        w_in_wait;
  logic        w_start;

  assign w_idle    = (r_state == c_idle);
  assign w_in_wait = (r_state == c_rd_wait) || (r_state == c_wr_wait);
  assign w_start   = w_idle && (Mem_Read || Mem_Write);

  // Next-state decode: read beats write at start, ready beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (Mem_Read)       w_state_nxt = c_rd_wait;
        else if (Mem_Write) w_state_nxt = c_wr_wait;
      end
      c_rd_wait, c_wr_wait: begin
        if (Mem_Ready)                w_state_nxt = c_done;
        else if (r_cnt == c_tmo_last) w_state_nxt = c_err;
      end
      c_done:  w_state_nxt = c_idle;
      c_err:   w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= c_idle;
    else          r_state <= w_state_nxt;
  end

  // MAR loads from the bus only while idle, so it is frozen during a transaction.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)             r_mar <= 16'h0000;
    else if (w_idle && LD_MAR) r_mar <= Bus_In;
  end

  // MDR loads from the bus while idle, or captures read data on a successful read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                                r_mdr <= 16'h0000;
    else if (w_idle && LD_MDR)                   r_mdr <= Bus_In;
    else if ((r_state == c_rd_wait) && Mem_Ready) r_mdr <= Mem_RData;
  end

  // Wait-cycle counter: cleared on start, counts not-ready cycles, saturates at 255.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                                    r_cnt <= 8'd0;
    else if (w_start)                                r_cnt <= 8'd0;
    else if (w_in_wait && !Mem_Ready && (r_cnt != 8'hFF)) r_cnt <= r_cnt + 8'd1;
  end

  // Sticky error flag: set on leaving the error state, cleared by the next start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)               r_err <= 1'b0;
    else if (w_start)           r_err <= 1'b0;
    else if (r_state == c_err)  r_err <= 1'b1;
  end

  assign MAR_Out   = r_mar;
  assign MDR_Out   = r_mdr;
  assign Mem_Addr  = r_mar;
  assign Mem_WData = r_mdr;
  assign Mem_Req   = w_in_wait;
  assign Mem_WE    = (r_state == c_wr_wait);
  assign Busy      = w_in_wait;
  assign Done      = (r_state == c_done);
  assign Err_Flag  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_io_unit                                         |
// | Description : Directed self-checking bench for mem_io_unit with an   |
// |               expected-MDR scoreboard queue.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mem_io_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Bus_In;
  logic        LD_MAR, LD_MDR, Mem_Read, Mem_Write, Mem_Ready;
  logic [15:0] Mem_RData;
  logic [15:0] MAR_Out, MDR_Out, Mem_Addr, Mem_WData;
  logic        Mem_Req, Mem_WE, Busy, Done, Err_Flag;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] sb_q[$];

  mem_io_unit #(.TIMEOUT_CYCLES(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Bus_In(Bus_In),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_Ready(Mem_Ready), .Mem_RData(Mem_RData),
    .MAR_Out(MAR_Out), .MDR_Out(MDR_Out), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_Req(Mem_Req), .Mem_WE(Mem_WE), .Busy(Busy), .Done(Done), .Err_Flag(Err_Flag)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pop the next expected MDR value and compare it with the DUT.
  task automatic sb_check(input string tag);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      chk(tag, MDR_Out, e);
    end
  endtask

  // Drive the memory side from the first wait cycle until the unit is back to idle.
  task automatic run_txn(input int ready_at, input logic [15:0] rdata, input logic [15:0] wexp,
                         input bit req_in_done, output int busy_n, output int we_n,
                         output int done_n, output int done_at);
    bit finished = 0;
    busy_n = 0; we_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 300; i++) begin
      Mem_Read = req_in_done && Done;
      if (Done) begin
        done_n++;
        done_at = i;
      end
      if (Busy) begin
        busy_n++;
        if (Mem_WE && (Mem_WData == wexp)) we_n++;
        Mem_Ready = (busy_n == ready_at);
        Mem_RData = rdata;
      end else begin
        Mem_Ready = 1'b0;
        Mem_RData = 16'h0000;
      end
      if ((i > 0) && !Busy && !Done && !Mem_Req) begin
        finished = 1;
        break;
      end
      step();
    end
    Mem_Read  = 1'b0;
    Mem_Ready = 1'b0;
    chk("txn_end", finished, 1);
  endtask

  int busy_n, we_n, done_n, done_at;

  initial begin
    Reset_n = 1'b0; Bus_In = 16'h0; LD_MAR = 0; LD_MDR = 0;
    Mem_Read = 0; Mem_Write = 0; Mem_Ready = 0; Mem_RData = 16'h0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_req", Mem_Req, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", Err_Flag, 0);
    chk("rst_mar", MAR_Out, 16'h0);
    chk("rst_mdr", MDR_Out, 16'h0);
    Reset_n = 1'b1;
    step();

    // Load MAR, zero-wait read
    Bus_In = 16'h3001; LD_MAR = 1; step(); LD_MAR = 0;
    Mem_Read = 1; sb_q.push_back(16'hBEEF); step(); Mem_Read = 0;
    chk("rd0_req_latency", Mem_Req, 1);
    chk("rd0_we", Mem_WE, 0);
    chk("rd0_addr", Mem_Addr, 16'h3001);
    run_txn(1, 16'hBEEF, 16'h0, 0, busy_n, we_n, done_n, done_at);
    chk("rd0_busy_cycles", busy_n, 1);
    chk("rd0_done_count", done_n, 1);
    chk("rd0_done_at", done_at, 1);
    step();
    sb_check("rd0_mdr");

    // Write with 3 wait states
    Bus_In = 16'h1234; LD_MDR = 1; step(); LD_MDR = 0;
    Bus_In = 16'h4000; LD_MAR = 1; step(); LD_MAR = 0;
    Mem_Write = 1; sb_q.push_back(16'h1234); step(); Mem_Write = 0;
    chk("wr_addr", Mem_Addr, 16'h4000);
    run_txn(4, 16'hDEAD, 16'h1234, 0, busy_n, we_n, done_n, done_at);
    chk("wr_busy_cycles", busy_n, 4);
    chk("wr_we_cycles", we_n, 4);
    chk("wr_done_count", done_n, 1);
    chk("wr_done_at", done_at, 4);
    step();
    sb_check("wr_mdr");

    // Timeout: ready never arrives
    Mem_Read = 1; sb_q.push_back(16'h1234); step(); Mem_Read = 0;
    run_txn(0, 16'hCAFE, 16'h0, 0, busy_n, we_n, done_n, done_at);
    chk("tmo_busy_cycles", busy_n, 15);
    chk("tmo_done_count", done_n, 0);
    step();
    chk("tmo_err_flag", Err_Flag, 1);
    sb_check("tmo_mdr");

    // Next read clears the flag; ready in the 15th wait cycle still succeeds
    Mem_Read = 1; sb_q.push_back(16'h5555); step(); Mem_Read = 0;
    chk("clr_err_on_start", Err_Flag, 0);
    run_txn(15, 16'h5555, 16'h0, 0, busy_n, we_n, done_n, done_at);
    chk("edge_busy_cycles", busy_n, 15);
    chk("edge_done_count", done_n, 1);
    step();
    chk("edge_err_flag", Err_Flag, 0);
    sb_check("edge_mdr");

    // Simultaneous read/write with MAR load; LD_MDR ignored while waiting
    Bus_In = 16'h00FF; LD_MAR = 1; Mem_Read = 1; Mem_Write = 1;
    sb_q.push_back(16'h7777); step();
    LD_MAR = 0; Mem_Read = 0; Mem_Write = 0;
    chk("sim_addr", Mem_Addr, 16'h00FF);
    chk("sim_we", Mem_WE, 0);
    chk("sim_req", Mem_Req, 1);
    Bus_In = 16'hAAAA; LD_MDR = 1; Mem_Ready = 0; step(); LD_MDR = 0;
    chk("sim_ldmdr_ignored", MDR_Out, 16'h5555);
    run_txn(1, 16'h7777, 16'h0, 0, busy_n, we_n, done_n, done_at);
    chk("sim_done_count", done_n, 1);
    step();
    sb_check("sim_mdr");

    // Read request during DONE is ignored
    Mem_Read = 1; sb_q.push_back(16'h1111); step(); Mem_Read = 0;
    run_txn(1, 16'h1111, 16'h0, 1, busy_n, we_n, done_n, done_at);
    chk("dreq_done_count", done_n, 1);
    step();
    chk("dreq_req", Mem_Req, 0);
    chk("dreq_busy", Busy, 0);
    sb_check("dreq_mdr");

    // Asynchronous reset in the middle of a read wait
    Mem_Read = 1; step(); Mem_Read = 0;
    step(); step();
    chk("arst_pre_req", Mem_Req, 1);
    #2; Reset_n = 1'b0; #1;
    chk("arst_req", Mem_Req, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_we", Mem_WE, 0);
    chk("arst_done", Done, 0);
    chk("arst_mar", MAR_Out, 16'h0);
    chk("arst_mdr", MDR_Out, 16'h0);
    @(negedge Clk); Reset_n = 1'b1;
    step();
    chk("arst_idle_req", Mem_Req, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
